aes_req_arbiter: RTL and testbench

Shares one AES-256 `cipher` core among NUM_REQ requesters. Each request is a plaintext/key pair. The block grants requesters round-robin, latches the granted operands, and pulses the core start (the core's ready_i). It then waits for core done with a timeout and returns the ciphertext tagged with the requester id over a valid/ready response channel. It sits between the requester fabric and the single `cipher` instance.

---
 rtl/aes_req_arbiter.sv | 166 ++++++++++++++++
 tb/tb_aes_req_arbiter.sv | 489 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_req_arbiter.sv
// Round-robin front end for a single shared AES-256 core: grants one requester at a time,
// launches the core, waits for done or a timeout, and returns a tagged response.
module aes_req_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = 64,
  parameter int ID_W        = $clog2(NUM_REQ)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NUM_REQ-1:0]     req_valid_i,
  output logic [NUM_REQ-1:0]     req_ready_o,
  input  logic [NUM_REQ*128-1:0] req_plain_i,
  input  logic [NUM_REQ*256-1:0] req_key_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [ID_W-1:0]        rsp_id_o,
  output logic [127:0]           rsp_data_o,
  output logic                   rsp_err_o,
  output logic                   busy_o,
  output logic                   core_start_o,
  output logic [127:0]           core_plain_o,
  output logic [255:0]           core_key_o,
  input  logic                   core_done_i,
  input  logic [127:0]           core_cipher_i,
  output logic [1:0]             dbg_state_o
);

  // Both channels use valid/ready: a transfer happens on a rising edge where valid and
  // ready are both high; the sender holds valid and payload stable until that edge.

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [127:0]     plain_q, plain_d;
  logic [255:0]     key_q, key_d;
  logic [127:0]     data_q, data_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             gnt_found;
  logic [ID_W-1:0]  gnt_id;
  logic [ID_W:0]    cand_sum;
  logic [ID_W-1:0]  cand;
  logic [127:0]     plain_sel;
  logic [255:0]     key_sel;

  // Search starts at the pointer and wraps, so the first hit is the round-robin winner.
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    cand_sum  = '0;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand_sum = {1'b0, ptr_q} + (ID_W+1)'(i);
      if (cand_sum >= (ID_W+1)'(NUM_REQ)) begin
        cand_sum = cand_sum - (ID_W+1)'(NUM_REQ);
      end
      cand = cand_sum[ID_W-1:0];
      if (!gnt_found && req_valid_i[cand]) begin
        gnt_found = 1'b1;
        gnt_id    = cand;
      end
    end
  end

  always_comb begin
    plain_sel = '0;
    key_sel   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (gnt_id == ID_W'(k)) begin
        plain_sel = req_plain_i[k*128 +: 128];
        key_sel   = req_key_i[k*256 +: 256];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    id_d         = id_q;
    plain_d      = plain_q;
    key_d        = key_q;
    data_d       = data_q;
    err_d        = err_q;
    cnt_d        = cnt_q;
    req_ready_o  = '0;
    core_start_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (gnt_found) begin
          req_ready_o[gnt_id] = 1'b1;
          id_d    = gnt_id;
          plain_d = plain_sel;
          key_d   = key_sel;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        core_start_o = 1'b1;
        cnt_d        = '0;
        state_d      = BUSY;
      end
      BUSY: begin
        cnt_d = cnt_q + 1'b1;
        // A done on the final allowed cycle still counts as success.
        if (core_done_i) begin
          data_d  = core_cipher_i;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          data_d  = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          ptr_d   = (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      plain_q <= '0;
      key_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      plain_q <= plain_d;
      key_q   <= key_d;
      data_q  <= data_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rsp_valid_o  = (state_q == RESP);
  assign rsp_id_o     = id_q;
  assign rsp_data_o   = data_q;
  assign rsp_err_o    = err_q;
  assign busy_o       = (state_q != IDLE);
  assign core_plain_o = plain_q;
  assign core_key_o   = key_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_aes_req_arbiter.sv
// Bench for aes_req_arbiter: a behavioural core stand-in plus a scoreboard that predicts
// each response (id, data, error) at grant time and checks it at the response handshake.
module tb_aes_req_arbiter;

  localparam int NR  = 4;
  localparam int TO  = 32;
  localparam int IDW = 2;
  localparam int EW  = 1 + IDW + 128;

  localparam logic [127:0] FIPS_P = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] FIPS_K = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] FIPS_C = 128'h8ea2b7ca516745bfeafc49904b496089;

  // ---------------- clock / reset / signals ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst = 1'b1;
  logic [NR-1:0]     req_valid = '0;
  logic [NR-1:0]     req_ready;
  logic [NR*128-1:0] req_plain = '0;
  logic [NR*256-1:0] req_key = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [IDW-1:0]    rsp_id;
  logic [127:0]      rsp_data;
  logic              rsp_err;
  logic              busy;
  logic              core_start;
  logic [127:0]      core_plain;
  logic [255:0]      core_key;
  logic              core_done;
  logic [127:0]      core_cipher = '0;
  logic [1:0]        dbg_state;

  logic              mdl_done = 1'b0;
  logic              stray_done = 1'b0;
  assign core_done = mdl_done | stray_done;

  int vectors = 0;
  int miscompares = 0;
  logic [EW-1:0] exp_q[$];
  int gnt_log[$];
  int core_lat = 14;
  logic core_mute = 1'b0;

  aes_req_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYC(TO)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_plain_i(req_plain), .req_key_i(req_key),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_id_o(rsp_id), .rsp_data_o(rsp_data), .rsp_err_o(rsp_err),
    .busy_o(busy), .core_start_o(core_start),
    .core_plain_o(core_plain), .core_key_o(core_key),
    .core_done_i(core_done), .core_cipher_i(core_cipher),
    .dbg_state_o(dbg_state)
  );

  // Stand-in core transform; only the FIPS-197 pair yields real AES-256 ciphertext.
  function automatic logic [127:0] model_ct(input logic [127:0] p, input logic [255:0] k);
    if (p == FIPS_P && k == FIPS_K) return FIPS_C;
    return p ^ k[127:0] ^ {k[191:128], k[255:192]} ^ 128'hc3c3_5a5a_0f0f_9696_c3c3_5a5a_0f0f_9696;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [255:0] rand256();
    return {rand128(), rand128()};
  endfunction

  // Core model: done is raised core_lat cycles after the start pulse.
  int mdl_rem = 0;
  logic mdl_active = 1'b0;
  logic [127:0] mdl_p;
  logic [255:0] mdl_k;
  always @(posedge clk) begin
    #2;
    mdl_done = 1'b0;
    if (rst) begin
      mdl_active = 1'b0;
    end else begin
      if (mdl_active) begin
        mdl_rem = mdl_rem - 1;
        if (mdl_rem == 0) begin
          mdl_done    = 1'b1;
          mdl_active  = 1'b0;
          core_cipher = model_ct(mdl_p, mdl_k);
        end
      end
      if (core_start && !core_mute) begin
        mdl_active = 1'b1;
        mdl_rem    = core_lat;
        mdl_p      = core_plain;
        mdl_k      = core_key;
      end
    end
  end

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    logic [EW-1:0] e;
    logic          terr;
    if (rst) begin
      exp_q.delete();
    end else begin
      vectors++;
      if ($countones(req_ready) > 1 || (req_ready & ~req_valid) != '0) begin
        miscompares++;
        $display("FAIL grant_shape: req_ready=%b with req_valid=%b, required one-hot subset of valid",
                 req_ready, req_valid);
      end
      for (int k = 0; k < NR; k++) begin
        if (req_valid[k] && req_ready[k]) begin
          gnt_log.push_back(k);
          terr = core_mute || (core_lat > TO);
          exp_q.push_back({terr, IDW'(k),
                           terr ? 128'h0 : model_ct(req_plain[k*128 +: 128], req_key[k*256 +: 256])});
        end
      end
      if (rsp_valid && rsp_ready) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_rsp: id=%0d data=%h err=%b, required no response",
                   rsp_id, rsp_data, rsp_err);
        end else begin
          e = exp_q.pop_front();
          if ({rsp_err, rsp_id, rsp_data} !== e) begin
            miscompares++;
            $display("FAIL rsp_payload: err=%b id=%0d data=%h, required err=%b id=%0d data=%h",
                     rsp_err, rsp_id, rsp_data, e[EW-1], e[EW-2 -: IDW], e[127:0]);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) tick();
    rst = 1'b0;
  endtask

  task automatic set_req(input int k, input logic [127:0] p, input logic [255:0] kk);
    req_plain[k*128 +: 128] = p;
    req_key[k*256 +: 256]   = kk;
    req_valid[k]            = 1'b1;
  endtask

  // Raise a request, wait for its grant, drop valid; returns at the start of the ISSUE cycle.
  task automatic issue_one(input int k, input logic [127:0] p, input logic [255:0] kk);
    int n = 0;
    set_req(k, p, kk);
    @(negedge clk);
    while (!req_ready[k] && n < 200) begin
      tick();
      @(negedge clk);
      n++;
    end
    vectors++;
    if (!req_ready[k]) begin
      miscompares++;
      $display("FAIL grant_wait: requester %0d not granted after %0d cycles, required a grant", k, n);
    end
    tick();
    req_valid[k] = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || dbg_state != 2'd0) && n < budget) begin
      tick();
      @(negedge clk);
      n++;
    end
    vectors++;
    if (exp_q.size() != 0 || dbg_state != 2'd0) begin
      miscompares++;
      $display("FAIL %s_drain: %0d responses outstanding state=%0d, required 0 and IDLE",
               name, exp_q.size(), dbg_state);
    end
    tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    req_valid = '0;
    rsp_ready = 1'b0;
    do_reset(2);
    @(negedge clk);
    vectors++;
    if ({dbg_state, busy, rsp_valid, core_start, req_ready} !== '0) begin
      miscompares++;
      $display("FAIL reset_ctrl: state=%0d busy=%b rsp_valid=%b start=%b ready=%b, required all 0",
               dbg_state, busy, rsp_valid, core_start, req_ready);
    end
    vectors++;
    if ({core_plain, core_key, rsp_data, rsp_id, rsp_err} !== '0) begin
      miscompares++;
      $display("FAIL reset_data: plain=%h key=%h data=%h id=%0d err=%b, required all 0",
               core_plain, core_key, rsp_data, rsp_id, rsp_err);
    end
    tick();
  endtask

  task automatic test_fips();
    core_lat  = 14;
    core_mute = 1'b0;
    rsp_ready = 1'b1;
    set_req(0, FIPS_P, FIPS_K);
    @(negedge clk);
    vectors++;
    if (req_ready !== 4'b0001) begin
      miscompares++;
      $display("FAIL fips_grant: req_ready=%b, required 0001", req_ready);
    end
    tick();
    req_valid[0] = 1'b0;
    @(negedge clk);
    vectors++;
    if (core_start !== 1'b1 || core_plain !== FIPS_P || core_key !== FIPS_K || req_ready !== '0) begin
      miscompares++;
      $display("FAIL fips_start: start=%b plain=%h key=%h ready=%b, required 1 with FIPS operands",
               core_start, core_plain, core_key, req_ready);
    end
    tick();
    @(negedge clk);
    vectors++;
    if (core_start !== 1'b0) begin
      miscompares++;
      $display("FAIL fips_start_width: start=%b one cycle later, required 0", core_start);
    end
    repeat (13) tick();
    @(negedge clk);
    vectors++;
    if (rsp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL fips_early: rsp_valid=%b at T+15, required 0", rsp_valid);
    end
    tick();
    @(negedge clk);
    vectors++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== FIPS_C || rsp_err !== 1'b0) begin
      miscompares++;
      $display("FAIL fips_rsp: valid=%b id=%0d data=%h err=%b, required 1/0/%h/0",
               rsp_valid, rsp_id, rsp_data, rsp_err, FIPS_C);
    end
    tick();
    @(negedge clk);
    vectors++;
    if (rsp_valid !== 1'b0 || dbg_state !== 2'd0) begin
      miscompares++;
      $display("FAIL fips_release: rsp_valid=%b state=%0d, required 0 and IDLE", rsp_valid, dbg_state);
    end
    tick();
  endtask

  task automatic test_round_robin();
    int exp_ord[6] = '{0, 1, 2, 3, 0, 1};
    int n = 0;
    do_reset(1);
    core_lat  = 3;
    rsp_ready = 1'b1;
    gnt_log.delete();
    for (int k = 0; k < NR; k++) set_req(k, rand128(), rand256());
    while (gnt_log.size() < 6 && n < 400) begin
      tick();
      @(negedge clk);
      n++;
    end
    tick();
    req_valid = '0;
    vectors++;
    if (gnt_log.size() < 6) begin
      miscompares++;
      $display("FAIL rr_count: %0d grants, required 6", gnt_log.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        vectors++;
        if (gnt_log[i] != exp_ord[i]) begin
          miscompares++;
          $display("FAIL rr_order: grant %0d went to %0d, required %0d", i, gnt_log[i], exp_ord[i]);
        end
      end
    end
    wait_drain("rr", 200);
  endtask

  task automatic test_backpressure();
    logic [EW-1:0] held;
    int n = 0;
    core_lat  = 5;
    rsp_ready = 1'b0;
    issue_one(3, rand128(), rand256());
    set_req(0, rand128(), rand256());
    @(negedge clk);
    while (!rsp_valid && n < 100) begin
      tick();
      @(negedge clk);
      n++;
    end
    held = {rsp_err, rsp_id, rsp_data};
    for (int c = 0; c < 5; c++) begin
      tick();
      @(negedge clk);
      vectors++;
      if (rsp_valid !== 1'b1 || {rsp_err, rsp_id, rsp_data} !== held || req_ready !== '0 || core_start !== 1'b0) begin
        miscompares++;
        $display("FAIL bp_hold: cycle %0d valid=%b payload=%h ready=%b start=%b, required 1/%h/0/0",
                 c, rsp_valid, {rsp_err, rsp_id, rsp_data}, req_ready, core_start, held);
      end
    end
    tick();
    rsp_ready = 1'b1;
    tick();
    @(negedge clk);
    vectors++;
    if (rsp_valid !== 1'b0 || dbg_state !== 2'd0 || req_ready !== 4'b0001) begin
      miscompares++;
      $display("FAIL bp_release: valid=%b state=%0d ready=%b, required 0/IDLE/0001",
               rsp_valid, dbg_state, req_ready);
    end
    tick();
    req_valid[0] = 1'b0;
    wait_drain("bp", 200);
  endtask

  task automatic test_timeout();
    core_mute = 1'b1;
    rsp_ready = 1'b0;
    issue_one(2, rand128(), rand256());
    @(negedge clk);
    vectors++;
    if (core_start !== 1'b1) begin
      miscompares++;
      $display("FAIL to_start: start=%b in ISSUE, required 1", core_start);
    end
    for (int k = 1; k <= TO; k++) begin
      tick();
      @(negedge clk);
      vectors++;
      if (rsp_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL to_early: rsp_valid=%b %0d cycles after ISSUE, required 0", rsp_valid, k);
      end
    end
    tick();
    @(negedge clk);
    vectors++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_data !== '0 || rsp_id !== 2'd2) begin
      miscompares++;
      $display("FAIL to_rsp: valid=%b err=%b data=%h id=%0d, required 1/1/0/2",
               rsp_valid, rsp_err, rsp_data, rsp_id);
    end
    core_mute = 1'b0;
    tick();
    stray_done = 1'b1;
    tick();
    stray_done = 1'b0;
    @(negedge clk);
    vectors++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_data !== '0) begin
      miscompares++;
      $display("FAIL to_late_done: valid=%b err=%b data=%h, required 1/1/0", rsp_valid, rsp_err, rsp_data);
    end
    tick();
    rsp_ready = 1'b1;
    wait_drain("to", 50);
    core_lat = TO;
    issue_one(3, rand128(), rand256());
    wait_drain("to_last_cycle", 100);
    core_lat = TO + 1;
    issue_one(0, rand128(), rand256());
    wait_drain("to_one_late", 100);
  endtask

  task automatic test_reset_busy();
    core_lat  = 20;
    rsp_ready = 1'b1;
    issue_one(1, rand128(), rand256());
    wait_drain("rb_pre", 100);
    issue_one(2, rand128(), rand256());
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if ({dbg_state, busy, rsp_valid, core_start, req_ready, rsp_id, rsp_err} !== '0 ||
        {core_plain, core_key, rsp_data} !== '0) begin
      miscompares++;
      $display("FAIL rb_outputs: state=%0d busy=%b valid=%b start=%b plain=%h data=%h, required all 0",
               dbg_state, busy, rsp_valid, core_start, core_plain, rsp_data);
    end
    tick();
    req_valid[1] = 1'b1;
    req_valid[2] = 1'b1;
    @(negedge clk);
    vectors++;
    if (req_ready !== 4'b0010) begin
      miscompares++;
      $display("FAIL rb_pointer: req_ready=%b with 1 and 2 valid, required 0010", req_ready);
    end
    tick();
    req_valid[1] = 1'b0;
    wait_drain("rb_first", 100);
    req_valid[2] = 1'b0;
    issue_one(2, req_plain[2*128 +: 128], req_key[2*256 +: 256]);
    wait_drain("rb_regrant", 100);
  endtask

  task automatic test_stray_and_boundaries();
    int n = 0;
    core_lat  = 4;
    rsp_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      stray_done = (c % 2 == 0);
      tick();
      @(negedge clk);
      vectors++;
      if (rsp_valid !== 1'b0 || dbg_state !== 2'd0) begin
        miscompares++;
        $display("FAIL stray_done: rsp_valid=%b state=%0d, required 0 and IDLE", rsp_valid, dbg_state);
      end
    end
    stray_done = 1'b0;
    issue_one(0, rand128(), rand256());
    set_req(1, rand128(), rand256());
    @(negedge clk);
    while (!rsp_valid && n < 100) begin
      tick();
      @(negedge clk);
      n++;
    end
    tick();
    req_valid = 4'b1000;
    req_plain[3*128 +: 128] = rand128();
    @(negedge clk);
    vectors++;
    if (req_ready !== 4'b1000) begin
      miscompares++;
      $display("FAIL swap_grant: req_ready=%b after 1 dropped and 3 rose, required 1000", req_ready);
    end
    tick();
    req_valid = '0;
    wait_drain("swap", 100);
    for (int k = 0; k < NR; k++) begin
      req_plain[k*128 +: 128] = rand128();
      req_key[k*256 +: 256]   = rand256();
    end
    for (int c = 0; c < 80; c++) begin
      tick();
      req_valid = 4'($urandom_range(0, 15));
      rsp_ready = 1'($urandom_range(0, 1));
    end
    tick();
    req_valid = '0;
    rsp_ready = 1'b1;
    wait_drain("rand", 200);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fips();
    test_round_robin();
    test_backpressure();
    test_timeout();
    test_reset_busy();
    test_stray_and_boundaries();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
